// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the 4-bit accumulator CPU.
// Owns PC, ACC, IR and the output port; fetches over req/valid and writes ALU results back.
module acc_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       fetch_req,
  output logic [3:0] instr_addr,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic [3:0] alu_acc,
  output logic [3:0] alu_imm,
  output logic [3:0] alu_opcode,
  input  logic [3:0] alu_result,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       zero,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_JMP  = 4'h6,
    OP_JZ   = 4'h7,
    OP_OUT  = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_pc;
  logic [3:0]  r_acc;
  logic [7:0]  r_ir;
  logic [3:0]  r_out_data;
  logic        r_out_valid;
  logic [3:0]  w_pc_next;
  logic [3:0]  w_imm;
  logic        w_exec;
  opcode_t     w_op;

  assign w_op   = opcode_t'(r_ir[7:4]);
  assign w_imm  = r_ir[3:0];
  assign w_exec = (r_state == S_EXEC);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (run) w_next_state = S_FETCH;
      S_FETCH: if (instr_valid) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_HALT) w_next_state = S_HALT;
        else if (run)        w_next_state = S_FETCH;
        else                 w_next_state = S_IDLE;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // JZ tests ACC as it stands before this instruction executes.
  always_comb begin
    w_pc_next = r_pc + 4'd1;
    case (w_op)
      OP_JMP:  w_pc_next = w_imm;
      OP_JZ:   if (r_acc == 4'd0) w_pc_next = w_imm;
      OP_HALT: w_pc_next = r_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_acc       <= '0;
      r_ir        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= w_exec && (w_op == OP_OUT);
      if (r_state == S_FETCH && instr_valid) r_ir <= instr;
      if (w_exec) begin
        r_pc <= w_pc_next;
        case (w_op)
          OP_LDI:                         r_acc <= w_imm;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  r_acc <= alu_result;
          OP_OUT:                         r_out_data <= r_acc;
          default: ;
        endcase
      end
    end
  end

  assign fetch_req  = (r_state == S_FETCH);
  assign halted     = (r_state == S_HALT);
  assign instr_addr = r_pc;
  assign alu_acc    = r_acc;
  assign alu_imm    = r_ir[3:0];
  assign alu_opcode = w_exec ? r_ir[7:4] : '0;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign zero       = (r_acc == 4'd0);

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed self-checking bench for acc_sequencer with a behavioural ROM and ALU.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       fetch_req;
  logic [3:0] instr_addr;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] alu_acc;
  logic [3:0] alu_imm;
  logic [3:0] alu_opcode;
  logic [3:0] alu_result;
  logic [3:0] out_data;
  logic       out_valid;
  logic       zero;
  logic       halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [16];
  int         delay = 0;
  int         wcnt;
  int         ov_cnt = 0;
  int         viol = 0;
  logic       prev_req = 1'b0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [3:0] trace [$];

  acc_sequencer #(.RESET_PC(4'h0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .fetch_req(fetch_req), .instr_addr(instr_addr),
    .instr(instr), .instr_valid(instr_valid),
    .alu_acc(alu_acc), .alu_imm(alu_imm), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid),
    .zero(zero), .halted(halted)
  );

  always #5 clk = ~clk;

  assign instr       = rom[instr_addr];
  assign instr_valid = fetch_req && (wcnt == delay);

  always_comb begin
    alu_result = 4'h0;
    case (alu_opcode)
      4'h2: alu_result = alu_acc + alu_imm;
      4'h3: alu_result = alu_acc - alu_imm;
      4'h4: alu_result = alu_acc & alu_imm;
      4'h5: alu_result = alu_acc | alu_imm;
      default: ;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (fetch_req && !instr_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (!rst && fetch_req && instr_valid) trace.push_back(instr_addr);
    if (!rst && prev_req && fetch_req && instr_addr != prev_addr) viol <= viol + 1;
    if (!rst && prev_req && !prev_valid && !fetch_req) viol <= viol + 1;
    prev_req   <= fetch_req && !rst;
    prev_valid <= instr_valid;
    prev_addr  <= instr_addr;
  end

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_prog(input logic [7:0] p0, p1, p2, p3, p4, p5);
    for (int unsigned i = 0; i < 16; i++) rom[i] = 8'hF0;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3; rom[4] = p4; rom[5] = p5;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%b required 1", name, halted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({fetch_req, halted, zero, out_valid} !== 4'b0010 || instr_addr !== 4'h0 ||
        alu_acc !== 4'h0 || alu_imm !== 4'h0 || alu_opcode !== 4'h0 || out_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: req=%b halt=%b zero=%b ov=%b addr=%h acc=%h imm=%h op=%h out=%h required 0 0 1 0 0 0 0 0 0",
               fetch_req, halted, zero, out_valid, instr_addr, alu_acc, alu_imm, alu_opcode, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_run: fetch_req=%b required 0", fetch_req);
    end
  endtask

  task automatic test_basic(input int dly, input int exp_lat, input string name);
    int n;
    int base_ov;
    int base_viol;
    int seen;
    delay = dly;
    load_prog(8'h13, 8'h24, 8'h80, 8'hF0, 8'hF0, 8'hF0);
    do_reset();
    base_ov = ov_cnt;
    base_viol = viol;
    run = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: out_valid after %0d cycles required %0d", name, n, exp_lat);
    end
    checks++;
    if (out_data !== 4'h7) begin
      errors++;
      $display("FAIL %s_out_data: got %h required 7", name, out_data);
    end
    wait_halt(name);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fetch_req) seen++;
    end
    checks++;
    if (seen !== 0 || instr_addr !== 4'h3 || alu_acc !== 4'h7) begin
      errors++;
      $display("FAIL %s_after_halt: fetches=%0d addr=%h acc=%h required 0 3 7", name, seen, instr_addr, alu_acc);
    end
    checks++;
    if (ov_cnt - base_ov !== 1) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d required 1", name, ov_cnt - base_ov);
    end
    checks++;
    if (viol - base_viol !== 0) begin
      errors++;
      $display("FAIL %s_fetch_stable: violations=%0d required 0", name, viol - base_viol);
    end
    run = 1'b0;
    delay = 0;
  endtask

  task automatic test_wrap_zero();
    int base_ov;
    delay = 0;
    load_prog(8'h12, 8'h35, 8'h80, 8'h80, 8'h10, 8'hF0);
    do_reset();
    base_ov = ov_cnt;
    run = 1'b1;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    checks++;
    if (out_data !== 4'hD || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: out=%h zero=%b required d 0", out_data, zero);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_pulse_width: out_valid=%b required 0", out_valid);
    end
    wait_halt("wrap");
    checks++;
    if (zero !== 1'b1 || alu_acc !== 4'h0 || out_data !== 4'hD) begin
      errors++;
      $display("FAIL ldi_zero: zero=%b acc=%h out=%h required 1 0 d", zero, alu_acc, out_data);
    end
    checks++;
    if (ov_cnt - base_ov !== 2) begin
      errors++;
      $display("FAIL back_to_back_out: pulses=%0d required 2", ov_cnt - base_ov);
    end
    run = 1'b0;
  endtask

  task automatic run_trace(input string name, input int len, input logic [3:0] exp [7]);
    int idx;
    do_reset();
    idx = trace.size();
    run = 1'b1;
    wait_halt(name);
    run = 1'b0;
    checks++;
    if (trace.size() - idx !== len) begin
      errors++;
      $display("FAIL %s_len: fetched %0d required %0d", name, trace.size() - idx, len);
    end else begin
      for (int k = 0; k < len; k++) begin
        checks++;
        if (trace[idx + k] !== exp[k]) begin
          errors++;
          $display("FAIL %s_addr%0d: got %h required %h", name, k, trace[idx + k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_jumps();
    logic [3:0] e [7];
    delay = 0;
    load_prog(8'h10, 8'h79, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
    rom[9] = 8'h11; rom[10] = 8'h79; rom[11] = 8'hF0;
    e = '{4'h0, 4'h1, 4'h9, 4'hA, 4'hB, 4'h0, 4'h0};
    run_trace("jz", 5, e);
    load_prog(8'h72, 8'hF0, 8'h11, 8'h6E, 8'hF0, 8'hF0);
    rom[14] = 8'h00; rom[15] = 8'h00;
    e = '{4'h0, 4'h2, 4'h3, 4'hE, 4'hF, 4'h0, 4'h1};
    run_trace("nop_wrap", 7, e);
    load_prog(8'h72, 8'hF0, 8'h11, 8'h6F, 8'hF0, 8'hF0);
    rom[15] = 8'h60;
    e = '{4'h0, 4'h2, 4'h3, 4'hF, 4'h0, 4'h1, 4'h0};
    run_trace("jmp_wrap", 6, e);
  endtask

  task automatic test_run_drop();
    delay = 0;
    load_prog(8'h13, 8'h24, 8'h80, 8'hF0, 8'hF0, 8'hF0);
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 20 && alu_opcode !== 4'h1; i++) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0 || instr_addr !== 4'h1 || alu_acc !== 4'h3 || halted !== 1'b0) begin
      errors++;
      $display("FAIL run_drop_idle: req=%b addr=%h acc=%h halt=%b required 0 1 3 0",
               fetch_req, instr_addr, alu_acc, halted);
    end
    run = 1'b1;
    wait_halt("resume");
    checks++;
    if (out_data !== 4'h7) begin
      errors++;
      $display("FAIL resume_result: out=%h required 7", out_data);
    end
    run = 1'b0;
  endtask

  task automatic test_async_reset();
    int idx;
    delay = 3;
    load_prog(8'h13, 8'h24, 8'h80, 8'hF0, 8'hF0, 8'hF0);
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 60 && !(fetch_req && instr_addr == 4'h2); i++) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    #1;
    checks++;
    if (fetch_req !== 1'b0 || instr_addr !== 4'h0 || alu_acc !== 4'h0 || zero !== 1'b1 || alu_imm !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_fetch: req=%b addr=%h acc=%h zero=%b imm=%h required 0 0 0 1 0",
               fetch_req, instr_addr, alu_acc, zero, alu_imm);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wait_halt("restart");
    checks++;
    if (out_data !== 4'h7) begin
      errors++;
      $display("FAIL restart_result: out=%h required 7", out_data);
    end
    rst = 1'b1;
    run = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || out_data !== 4'h0 || zero !== 1'b1 || instr_addr !== 4'h0) begin
      errors++;
      $display("FAIL rst_in_halt: halt=%b out=%h zero=%b addr=%h required 0 0 1 0",
               halted, out_data, zero, instr_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idx = trace.size();
    run = 1'b1;
    wait_halt("rerun");
    checks++;
    if (trace.size() <= idx || trace[idx] !== 4'h0 || out_data !== 4'h7) begin
      errors++;
      $display("FAIL rerun_entry: fetches=%0d out=%h required entry 0 out 7", trace.size() - idx, out_data);
    end
    run = 1'b0;
    delay = 0;
  endtask

  initial begin
    for (int unsigned i = 0; i < 16; i++) rom[i] = 8'hF0;
    test_reset();
    test_basic(0, 7, "zero_wait");
    test_wrap_zero();
    test_jumps();
    test_basic(3, 16, "stall");
    test_run_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Fetch/decode/execute controller for the 4-bit accumulator CPU.
- Fetches 8-bit instructions from an external program ROM over a req/valid handshake.
- Drives opcode, immediate and accumulator into the combinational ALU, then writes the ALU result back into ACC.
- Owns PC, ACC, IR and the output port. It sits between the program ROM and the ALU, at the top of the CPU datapath.

Parameters:
- RESET_PC, 4'h0: PC value loaded on reset (program entry point).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  enables instruction fetch; when low the core idles between instructions.
- fetch_req  output  1  high while in FETCH; requests the instruction at instr_addr.
- instr_addr  output  4  equals PC.
- instr  input  8  instruction word: [7:4] opcode, [3:0] imm; sampled only when instr_valid=1 in FETCH.
- instr_valid  input  1  ROM response strobe; may arrive any number of cycles after fetch_req rises.
- alu_acc  output  4  current ACC.
- alu_imm  output  4  IR[3:0].
- alu_opcode  output  4  IR[7:4] in EXEC, 4'h0 otherwise.
- alu_result  input  4  combinational ALU output, sampled at the end of EXEC.
- out_data  output  4  last value written by OUT.
- out_valid  output  1  one-cycle pulse when out_data updates.
- zero  output  1  (ACC == 0).
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, PC=RESET_PC, ACC=0, IR=0, out_data=0.
  - out_valid=0, fetch_req=0, halted=0, zero=1.
  - Reset asserted mid-fetch or mid-execute aborts immediately; any instr_valid arriving after reset release while not in FETCH is ignored.
- States: IDLE, FETCH, EXEC, HALT. fetch_req and halted are Moore outputs.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - fetch_req=1, instr_addr=PC.
  - On a cycle with instr_valid=1: IR<=instr, go to EXEC.
  - Otherwise stay, with no timeout.
  - run is ignored in FETCH; an outstanding fetch always completes.
- EXEC (exactly one cycle), acting on IR. PC<=PC+1 mod 16 unless stated otherwise:
  - 0 NOP: no effect.
  - 1 LDI: ACC<=imm.
  - 2 ADD, 3 SUB, 4 AND, 5 OR: ACC<=alu_result. Arithmetic is 4-bit wrap with no carry/borrow flag; that wrap is the ALU's behaviour, stored unchanged.
  - 6 JMP: PC<=imm.
  - 7 JZ: PC<=imm if ACC==0 at EXEC (value before this instruction), else PC+1.
  - 8 OUT: out_data<=ACC; out_valid=1 for the following cycle only.
  - F HALT: PC unchanged, go to HALT.
  - All other opcodes (9–E) behave as NOP.
- EXEC next state: HALT for opcode F; else FETCH if run=1; else IDLE.
- HALT: terminal. Only rst exits it. run and instr_valid are ignored; no further fetch_req.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with immediate valid, then EXEC).
  - ROM stall of N cycles gives 2+N cycles.
- PC wraps 15->0 on increment. JMP to the current PC is a legal tight loop.
- Two consecutive OUTs produce two separate out_valid pulses, at least 2 cycles apart.
- zero tracks ACC combinationally, including its reset value.

Test Plan:
- LDI 3, ADD 4, OUT, HALT with zero-wait ROM -> out_data=7, one out_valid pulse 7 cycles after run rises; halted=1; fetch_req stays 0 afterwards.
- LDI 2, SUB 5, OUT -> out_data=4'hD (wrap); zero=0. Then LDI 0 -> zero=1.
- LDI 0, JZ 9 -> next instr_addr=9. LDI 1, JZ 9 -> next instr_addr=PC+1. JMP 0 at address 15 loops correctly, and a NOP at address 15 wraps to 0.
- instr_valid delayed 3 cycles per fetch -> fetch_req held high and instr_addr stable throughout; each instruction takes 5 cycles; results identical to the zero-wait run.
- run dropped during EXEC -> state IDLE, fetch_req=0, PC holds. run reasserted -> resumes at the next PC with ACC intact.
- rst pulsed during FETCH and during HALT -> all outputs return to reset values asynchronously; execution restarts at RESET_PC once run=1.
